// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port IF/MEM memory arbiter.
// State encoding keeps IDLE<->BUSY moves to one flipped bit.
package mem_port_arbiter_pkg;

  localparam int ARB_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY_IF = 2'b01,
    ARB_BUSY_D  = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port: req/ack transaction bus between the
// arbiter (master) and the memory model (slave).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared I/D memory port: data first, with a
// starvation counter that forces a fetch grant periodically.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              flush,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  mem_port_arbiter_if.master mem
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic [CW-1:0] starve;
  logic          discard;
  logic          d_req;
  logic          starved;
  logic          gnt_d;
  logic          gnt_if;

  assign d_req   = MEM_R_EN | MEM_W_EN;
  assign starved = if_req && (starve >= CW'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_d     = 1'b0;
    gnt_if    = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (d_req && !starved) begin
          gnt_d     = 1'b1;
          state_nxt = ARB_BUSY_D;
        end else if (if_req && !flush) begin
          gnt_if    = 1'b1;
          state_nxt = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF,
      ARB_BUSY_D: begin
        if (mem.mem_ack) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // OR of state flops; every legal move flips a single bit
  always_comb begin
    mem.mem_req = |state;
    if_valid    = (state == ARB_BUSY_IF) && mem.mem_ack &&
                  !discard && !flush;
    d_valid     = (state == ARB_BUSY_D) && mem.mem_ack;
    d_stall     = d_req && !d_valid;
    if_stall    = (if_req && !if_valid) || d_stall;
    if_rdata    = mem.mem_rdata;
    d_rdata     = mem.mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_we    <= 1'b0;
    end else if (gnt_d) begin
      mem.mem_addr  <= d_addr;
      mem.mem_wdata <= d_wdata;
      mem.mem_we    <= MEM_W_EN;
    end else if (gnt_if) begin
      mem.mem_addr  <= if_addr;
      mem.mem_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (gnt_if || (gnt_d && !if_req)) begin
      starve <= '0;
    end else if (gnt_d && starve != CW'(STARVE_MAX)) begin
      starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= 1'b0;
    end else if (state != ARB_BUSY_IF || mem.mem_ack) begin
      discard <= 1'b0;
    end else if (flush) begin
      discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal
// expectations, then random traffic against a transaction model.
module tb_mem_port_arbiter;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush, r_en, w_en;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_valid, if_stall, d_valid, d_stall;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .if_stall(if_stall), .flush(flush),
    .MEM_R_EN(r_en), .MEM_W_EN(w_en),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .d_stall(d_stall), .mem(bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: who owns the port, how many data
  // grants in a row a waiting fetch has lost, and what was latched.
  int          m_owner = 0;
  int          m_run = 0;
  bit          m_dead = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          m_we = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= 0;
      m_run   <= 0;
      m_dead  <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_we    <= 1'b0;
    end else if (m_owner == 0) begin
      if ((r_en || w_en) && !(if_req && m_run >= SMAX)) begin
        m_owner <= 2;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_we    <= w_en;
        m_run   <= if_req ? ((m_run + 1 > SMAX) ? SMAX
                                                : m_run + 1) : 0;
      end else if (if_req && !flush) begin
        m_owner <= 1;
        m_addr  <= if_addr;
        m_we    <= 1'b0;
        m_run   <= 0;
      end
    end else if (bus.mem_ack) begin
      m_owner <= 0;
      m_dead  <= 1'b0;
    end else if (m_owner == 1 && flush) begin
      m_dead <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      automatic bit e_ifv = (m_owner == 1) && bus.mem_ack &&
                            !m_dead && !flush;
      automatic bit e_dv  = (m_owner == 2) && bus.mem_ack;
      automatic bit e_ds  = (r_en || w_en) && !e_dv;
      automatic bit e_is  = (if_req && !e_ifv) || e_ds;
      cmp("m_mem_req", 32'(bus.mem_req), 32'(m_owner != 0));
      cmp("m_mem_addr", bus.mem_addr, m_addr);
      cmp("m_mem_we", 32'(bus.mem_we), 32'(m_we));
      if (m_we) cmp("m_mem_wdata", bus.mem_wdata, m_wdata);
      cmp("m_if_valid", 32'(if_valid), 32'(e_ifv));
      cmp("m_d_valid", 32'(d_valid), 32'(e_dv));
      cmp("m_d_stall", 32'(d_stall), 32'(e_ds));
      cmp("m_if_stall", 32'(if_stall), 32'(e_is));
      if (e_ifv) cmp("m_if_rdata", if_rdata, bus.mem_rdata);
      if (e_dv) cmp("m_d_rdata", d_rdata, bus.mem_rdata);
    end
  end

  initial begin
    automatic logic [31:0] g[$];
    automatic logic [31:0] gexp[5] =
      '{32'h300, 32'h300, 32'h300, 32'h200, 32'h300};

    rst = 1'b1;
    if_req = 1'b1; r_en = 1'b1; w_en = 1'b0; flush = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    @(posedge clk);
    run_cmp = 1'b1;
    @(negedge clk);
    cmp("rst_mem_req", 32'(bus.mem_req), 0);
    cmp("rst_mem_addr", bus.mem_addr, 0);
    cmp("rst_mem_wdata", bus.mem_wdata, 0);
    cmp("rst_mem_we", 32'(bus.mem_we), 0);
    cmp("rst_valids", {30'd0, if_valid, d_valid}, 0);
    cmp("rst_stalls", {30'd0, if_stall, d_stall}, 32'd3);
    tick();
    if_req = 1'b0; r_en = 1'b0;
    tick();
    rst = 1'b0;

    repeat (10) begin
      tick();
      @(negedge clk);
      cmp("idle_mem_req", 32'(bus.mem_req), 0);
      cmp("idle_valids", {30'd0, if_valid, d_valid}, 0);
    end

    // single fetch
    tick();
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    cmp("fetch_if_valid", 32'(if_valid), 1);
    cmp("fetch_if_rdata", if_rdata, 32'hDEADBEEF);
    cmp("fetch_if_stall", 32'(if_stall), 0);
    cmp("fetch_mem_we", 32'(bus.mem_we), 0);
    cmp("fetch_mem_addr", bus.mem_addr, 32'h40);
    tick();
    bus.mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    cmp("fetch_valid_once", 32'(if_valid), 0);

    // priority: store beats fetch
    tick();
    if_req = 1'b1; if_addr = 32'h80;
    w_en = 1'b1; d_addr = 32'h100; d_wdata = 32'd5;
    tick();
    @(negedge clk);
    cmp("prio_mem_we", 32'(bus.mem_we), 1);
    cmp("prio_mem_addr", bus.mem_addr, 32'h100);
    cmp("prio_mem_wdata", bus.mem_wdata, 32'd5);
    tick();
    bus.mem_ack = 1'b1;
    @(negedge clk);
    cmp("prio_d_valid", 32'(d_valid), 1);
    cmp("prio_d_stall", 32'(d_stall), 0);
    tick();
    bus.mem_ack = 1'b0; w_en = 1'b0;
    tick();
    @(negedge clk);
    cmp("prio_if_grant", 32'(bus.mem_req), 1);
    cmp("prio_if_addr", bus.mem_addr, 32'h80);
    cmp("prio_if_we", 32'(bus.mem_we), 0);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h13;
    @(negedge clk);
    cmp("prio_if_valid", 32'(if_valid), 1);
    tick();
    bus.mem_ack = 1'b0; if_req = 1'b0;

    // starvation: 3 loads, then the fetch, then loads again
    tick();
    if_req = 1'b1; if_addr = 32'h200;
    r_en = 1'b1; d_addr = 32'h300;
    for (int i = 0; i < 20 && g.size() < 5; i++) begin
      tick();
      bus.mem_ack = bus.mem_req;
      if (bus.mem_req) g.push_back(bus.mem_addr);
    end
    tick();
    bus.mem_ack = 1'b0; r_en = 1'b0; if_req = 1'b0;
    cmp("starve_grants", g.size(), 5);
    for (int i = 0; i < 5; i++)
      cmp("starve_order", (i < g.size()) ? g[i] : '0, gexp[i]);

    // flush during a fetch
    tick();
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    bus.mem_ack = 1'b1;
    @(negedge clk);
    cmp("flush_no_valid", 32'(if_valid), 0);
    cmp("flush_busy", 32'(bus.mem_req), 1);
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    cmp("flush_idle", 32'(bus.mem_req), 0);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234;
    @(negedge clk);
    cmp("flush_next_valid", 32'(if_valid), 1);
    cmp("flush_next_rdata", if_rdata, 32'h1234);
    tick();
    bus.mem_ack = 1'b0; if_req = 1'b0;

    // reset in the middle of a data access
    tick();
    r_en = 1'b1; d_addr = 32'h500;
    tick();
    tick();
    rst = 1'b1; r_en = 1'b0;
    #1;
    cmp("rstmid_mem_req", 32'(bus.mem_req), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    cmp("rstmid_idle", 32'(bus.mem_req), 0);
    tick();
    bus.mem_ack = 1'b1;
    @(negedge clk);
    cmp("stray_ack_valid", {30'd0, if_valid, d_valid}, 0);
    tick();
    bus.mem_ack = 1'b0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if_req  = ($urandom_range(0, 9) < 7);
      r_en    = ($urandom_range(0, 9) < 4);
      w_en    = ($urandom_range(0, 9) < 2);
      flush   = ($urandom_range(0, 9) == 0);
      if_addr = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      bus.mem_rdata = $urandom;
      bus.mem_ack = bus.mem_req ? ($urandom_range(0, 1) == 1)
                                : ($urandom_range(0, 19) == 0);
    end
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single shared instruction/data memory port between the pipeline's IF stage and MEM stage. Data accesses take priority over fetches, with a starvation counter that guarantees fetch progress. The block issues a req/ack transaction to memory and drives the stall signals the hazard path uses to freeze the pipeline. It sits between the IF/MEM stages and the memory model, alongside `controller`, and consumes its `MEM_R_EN`/`MEM_W_EN`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 3, consecutive data grants allowed while a fetch waits (≥1)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  IF stage wants an instruction word
- `if_addr`  in  ADDR_W  fetch address (PC)
- `if_rdata`  out  DATA_W  fetched word, valid with `if_valid`
- `if_valid`  out  1  fetch complete this cycle
- `if_stall`  out  1  freeze PC/IF register
- `flush`  in  1  branch taken; discard any fetch in flight
- `MEM_R_EN`  in  1  MEM stage load
- `MEM_W_EN`  in  1  MEM stage store
- `d_addr`  in  ADDR_W  load/store address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, valid with `d_valid`
- `d_valid`  out  1  data access complete this cycle
- `d_stall`  out  1  freeze whole pipeline
- `mem_req`  out  1  transaction active; held until `mem_ack`
- `mem_we`  out  1  write transaction
- `mem_addr`  out  ADDR_W  registered address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_ack`  in  1  one-cycle completion pulse; `mem_rdata` valid same cycle
- `mem_rdata`  in  DATA_W  read data

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D. Reset → IDLE; starvation count 0; discard flag 0.
- The block is in IDLE and a data request is `MEM_R_EN|MEM_W_EN`:
  - If a data request is present and the starvation count is below `STARVE_MAX` (or `if_req` is low), grant data and go to BUSY_D.
  - Otherwise, if `if_req` is high and `flush` is low, grant IF and go to BUSY_IF.
  - Otherwise stay in IDLE.
- A grant registers `mem_addr`, `mem_wdata` and `mem_we` (`MEM_W_EN` for data, 0 for IF).
- `MEM_R_EN` and `MEM_W_EN` both high: treated as a store.
- Starvation count:
  - Increments on a data grant while `if_req` is high, saturating at `STARVE_MAX`.
  - Clears on an IF grant.
  - Clears on any grant while `if_req` is low.
- BUSY_x:
  - `mem_req` stays high and the registered address/data/we stay stable until `mem_ack`.
  - On `mem_ack`, go to IDLE.
- `if_valid` = BUSY_IF & `mem_ack` & !discard & !`flush`. `d_valid` = BUSY_D & `mem_ack`.
- `if_rdata`/`d_rdata` pass `mem_rdata` through combinationally.
- Discard: set when `flush` is high in BUSY_IF. Clears on leaving BUSY_IF. A discarded fetch still completes on the memory side but produces no `if_valid`.
- `d_stall` = (`MEM_R_EN`|`MEM_W_EN`) & !`d_valid`.
- `if_stall` = `if_req` & !`if_valid` | `d_stall`.
- Reset mid-transaction: return to IDLE immediately and drop `mem_req`. The memory model must abandon the transaction; a late `mem_ack` in IDLE is ignored.

## Timing
- Reset values: `mem_req`/`mem_we`/`if_valid`/`d_valid` = 0; `mem_addr`/`mem_wdata` = 0.
- Reset values of the stall outputs: `if_stall`/`d_stall` follow their combinational equations, i.e. they equal the request inputs.
- Minimum access time:
  - Request seen in IDLE at cycle 0.
  - `mem_req` high from cycle 1.
  - With `mem_ack` in cycle 1, `*_valid` pulses in cycle 1 and the FSM is in IDLE at cycle 2.
  - Peak throughput is one access per 2 cycles.
- `mem_req` is a registered state decode and is glitch-free.
- Combinational paths: `*_valid`, `*_rdata` and stalls depend on `mem_ack`/`mem_rdata` in the same cycle.
- `mem_ack` outside BUSY is ignored.
- A new request arriving during BUSY is held off by its stall. It is evaluated in the first IDLE cycle.

## Structure
- Add to `defines.v`:
  - State encoding constants `ARB_IDLE`, `ARB_BUSY_IF`, `ARB_BUSY_D` (2 bits).
  - Default `STARVE_MAX`.
- Single module; no sub-module. The starvation counter is a small always block inside `mem_port_arbiter`.

## Test plan
- Reset then idle: `if_req`=0, no data request → `mem_req`=0 for 10 cycles; all valids 0.
- Single fetch:
  - Stimulus: `if_addr`=0x40, `mem_ack` in the first BUSY cycle with `mem_rdata`=0xDEADBEEF.
  - Response: `if_valid`=1 for exactly 1 cycle with `if_rdata`=0xDEADBEEF; `if_stall`=0 that cycle; `mem_we`=0.
- Priority:
  - Stimulus: `if_req` and `MEM_W_EN` high together, `d_addr`=0x100, `d_wdata`=5.
  - Response: data granted first (`mem_we`=1, `mem_addr`=0x100, `mem_wdata`=5), then IF granted. `d_stall` is low on its ack.
- Starvation:
  - Stimulus: `if_req` held, continuous data loads, `STARVE_MAX`=3.
  - Response: exactly 3 data grants, then 1 IF grant, then data resumes.
- Flush:
  - Stimulus: `flush` pulsed in BUSY_IF 2 cycles before `mem_ack`.
  - Response: no `if_valid`; FSM returns to IDLE on ack; the next fetch is served normally.
- Reset mid-op: `rst` asserted in BUSY_D with `mem_ack` withheld → `mem_req`=0 the same cycle; IDLE after release; a stray `mem_ack` produces no valid.
